// File: rtl/argon_regfile_sequencer.sv
// Initiator side of the register-file shared bus. It runs one READ, WRITE or MOVE
// command at a time and returns the result on a valid/ready response port.
module argon_regfile_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_cmdValid,
    output logic                  o_cmdReady,
    input  logic [1:0]            i_cmdOp,
    input  logic [IDX_WIDTH-1:0]  i_cmdIdxA,
    input  logic [IDX_WIDTH-1:0]  i_cmdIdxB,
    input  logic [IDX_WIDTH-1:0]  i_cmdIdxC,
    input  logic [DATA_WIDTH-1:0] i_cmdData,
    output logic [DATA_WIDTH-1:0] o_busData,
    output logic                  o_busValid,
    input  logic [DATA_WIDTH-1:0] i_busData,
    input  logic                  i_busValid,
    output logic                  o_selectLatch,
    output logic                  o_outputA,
    output logic                  o_outputB,
    output logic                  o_latchC,
    output logic                  o_rspValid,
    input  logic                  i_rspReady,
    output logic [DATA_WIDTH-1:0] o_rspA,
    output logic [DATA_WIDTH-1:0] o_rspB,
    output logic                  o_rspErr
);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_MOVE    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        RD_A   = 3'd2,
        RD_B   = 3'd3,
        CAP_B  = 3'd4,
        CAP_A  = 3'd5,
        WRITE  = 3'd6,
        RSP    = 3'd7
    } state_t;

    state_t                state_r;
    state_t                nextState_s;
    logic [1:0]            op_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] capA_r;
    logic                  err_r;

    logic                  accept_s;
    logic [DATA_WIDTH-1:0] capANext_s;
    logic                  errNext_s;
    logic [DATA_WIDTH-1:0] idxWord_s;
    logic                  cmdReadyNext_s;
    logic [DATA_WIDTH-1:0] busDataNext_s;
    logic                  busValidNext_s;
    logic                  selectLatchNext_s;
    logic                  outputANext_s;
    logic                  outputBNext_s;
    logic                  latchCNext_s;
    logic                  rspValidNext_s;
    logic [DATA_WIDTH-1:0] rspANext_s;
    logic [DATA_WIDTH-1:0] rspBNext_s;
    logic                  rspErrNext_s;

    // o_cmdReady is a registered copy of (state_r == IDLE), so it doubles as the idle flag
    assign accept_s = i_cmdValid & o_cmdReady;

    // Next-state sequencing for each command type
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (i_cmdOp == OP_ILLEGAL) begin
                        nextState_s = RSP;
                    end else begin
                        nextState_s = SELECT;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            SELECT: begin
                if (op_r == OP_WRITE) begin
                    nextState_s = WRITE;
                end else begin
                    nextState_s = RD_A;
                end
            end
            RD_A: begin
                if (op_r == OP_MOVE) begin
                    nextState_s = CAP_A;
                end else begin
                    nextState_s = RD_B;
                end
            end
            RD_B:   nextState_s = CAP_B;
            CAP_B:  nextState_s = RSP;
            CAP_A:  nextState_s = WRITE;
            WRITE:  nextState_s = RSP;
            RSP: begin
                if (i_rspReady) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = RSP;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Data path: slave data lands one cycle after its strobe, so A is taken in RD_B or CAP_A
    always_comb begin
        capANext_s = capA_r;
        if ((state_r == RD_B) || (state_r == CAP_A)) begin
            capANext_s = i_busData;
        end else begin
            capANext_s = capA_r;
        end

        errNext_s = err_r;
        if (accept_s) begin
            errNext_s = (i_cmdOp == OP_ILLEGAL);
        end else if (((state_r == RD_A) || (state_r == RD_B)) && !i_busValid) begin
            errNext_s = 1'b1;
        end else begin
            errNext_s = err_r;
        end

        idxWord_s = {DATA_WIDTH{1'b0}};
        idxWord_s[IDX_WIDTH-1:0]             = i_cmdIdxA;
        idxWord_s[2*IDX_WIDTH-1:IDX_WIDTH]   = i_cmdIdxB;
        idxWord_s[3*IDX_WIDTH-1:2*IDX_WIDTH] = i_cmdIdxC;
    end

    // Output decode from the next state so every output leaves a register
    always_comb begin
        cmdReadyNext_s    = (nextState_s == IDLE);
        selectLatchNext_s = (nextState_s == SELECT);
        outputANext_s     = (nextState_s == RD_A);
        outputBNext_s     = (nextState_s == RD_B);
        latchCNext_s      = (nextState_s == WRITE);
        busValidNext_s    = (nextState_s == SELECT) || (nextState_s == WRITE);
        rspValidNext_s    = (nextState_s == RSP);

        busDataNext_s = {DATA_WIDTH{1'b0}};
        case (nextState_s)
            SELECT: busDataNext_s = idxWord_s;
            WRITE: begin
                if (op_r == OP_WRITE) begin
                    busDataNext_s = data_r;
                end else begin
                    busDataNext_s = capANext_s;
                end
            end
            default: busDataNext_s = {DATA_WIDTH{1'b0}};
        endcase

        rspANext_s   = {DATA_WIDTH{1'b0}};
        rspBNext_s   = {DATA_WIDTH{1'b0}};
        rspErrNext_s = 1'b0;
        if ((state_r == RSP) && (nextState_s == RSP)) begin
            rspANext_s   = o_rspA;
            rspBNext_s   = o_rspB;
            rspErrNext_s = o_rspErr;
        end else if (nextState_s == RSP) begin
            rspErrNext_s = errNext_s;
            case (state_r)
                CAP_B: begin
                    rspANext_s = capA_r;
                    rspBNext_s = i_busData;
                end
                WRITE: begin
                    rspANext_s = o_busData;
                    rspBNext_s = {DATA_WIDTH{1'b0}};
                end
                default: begin
                    rspANext_s = {DATA_WIDTH{1'b0}};
                    rspBNext_s = {DATA_WIDTH{1'b0}};
                end
            endcase
        end else begin
            rspANext_s   = {DATA_WIDTH{1'b0}};
            rspBNext_s   = {DATA_WIDTH{1'b0}};
            rspErrNext_s = 1'b0;
        end
    end

    // State, captured command fields and registered outputs
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r       <= IDLE;
            op_r          <= OP_READ;
            data_r        <= {DATA_WIDTH{1'b0}};
            capA_r        <= {DATA_WIDTH{1'b0}};
            err_r         <= 1'b0;
            o_cmdReady    <= 1'b1;
            o_busData     <= {DATA_WIDTH{1'b0}};
            o_busValid    <= 1'b0;
            o_selectLatch <= 1'b0;
            o_outputA     <= 1'b0;
            o_outputB     <= 1'b0;
            o_latchC      <= 1'b0;
            o_rspValid    <= 1'b0;
            o_rspA        <= {DATA_WIDTH{1'b0}};
            o_rspB        <= {DATA_WIDTH{1'b0}};
            o_rspErr      <= 1'b0;
        end else begin
            state_r <= nextState_s;
            if (accept_s) begin
                op_r   <= i_cmdOp;
                data_r <= i_cmdData;
            end else begin
                op_r   <= op_r;
                data_r <= data_r;
            end
            capA_r        <= capANext_s;
            err_r         <= errNext_s;
            o_cmdReady    <= cmdReadyNext_s;
            o_busData     <= busDataNext_s;
            o_busValid    <= busValidNext_s;
            o_selectLatch <= selectLatchNext_s;
            o_outputA     <= outputANext_s;
            o_outputB     <= outputBNext_s;
            o_latchC      <= latchCNext_s;
            o_rspValid    <= rspValidNext_s;
            o_rspA        <= rspANext_s;
            o_rspB        <= rspBNext_s;
            o_rspErr      <= rspErrNext_s;
        end
    end

endmodule

// File: tb/tb_argon_regfile_sequencer.sv
// Scoreboard bench for argon_regfile_sequencer with a behavioural register-file slave.
module tb_argon_regfile_sequencer;

    localparam int DW = 16;
    localparam int IW = 4;

    logic          i_Clk = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_cmdValid = 1'b0;
    logic          o_cmdReady;
    logic [1:0]    i_cmdOp = 2'b00;
    logic [IW-1:0] i_cmdIdxA = 4'h0;
    logic [IW-1:0] i_cmdIdxB = 4'h0;
    logic [IW-1:0] i_cmdIdxC = 4'h0;
    logic [DW-1:0] i_cmdData = 16'h0000;
    logic [DW-1:0] o_busData;
    logic          o_busValid;
    logic [DW-1:0] i_busData;
    logic          i_busValid;
    logic          o_selectLatch;
    logic          o_outputA;
    logic          o_outputB;
    logic          o_latchC;
    logic          o_rspValid;
    logic          i_rspReady = 1'b0;
    logic [DW-1:0] o_rspA;
    logic [DW-1:0] o_rspB;
    logic          o_rspErr;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          err;
        logic          dataChk;
    } rsp_t;
    rsp_t expQ[$];

    logic [DW-1:0] refRegs [16];

    // slave model
    logic [DW-1:0] slaveRegs [16];
    logic [DW-1:0] slaveData;
    logic [DW-1:0] slaveIdx;
    logic          slaveClear = 1'b1;
    logic          busValidEn = 1'b1;

    assign i_busData  = slaveData;
    assign i_busValid = busValidEn;

    argon_regfile_sequencer #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady), .i_cmdOp(i_cmdOp),
        .i_cmdIdxA(i_cmdIdxA), .i_cmdIdxB(i_cmdIdxB), .i_cmdIdxC(i_cmdIdxC),
        .i_cmdData(i_cmdData), .o_busData(o_busData), .o_busValid(o_busValid),
        .i_busData(i_busData), .i_busValid(i_busValid),
        .o_selectLatch(o_selectLatch), .o_outputA(o_outputA), .o_outputB(o_outputB),
        .o_latchC(o_latchC), .o_rspValid(o_rspValid), .i_rspReady(i_rspReady),
        .o_rspA(o_rspA), .o_rspB(o_rspB), .o_rspErr(o_rspErr)
    );

    always #5 i_Clk = ~i_Clk;

    // Register-file slave: latches index word, registers read data, writes on latchC
    always @(posedge i_Clk) begin
        if (slaveClear) begin
            for (int i = 0; i < 16; i++) slaveRegs[i] <= 16'h0000;
            slaveData <= 16'h0000;
            slaveIdx  <= 16'h0000;
        end else begin
            if (o_selectLatch && o_busValid) slaveIdx <= o_busData;
            if (o_outputA) begin
                slaveData <= (slaveIdx[3:0] == 4'h0) ? 16'h0000 : slaveRegs[slaveIdx[3:0]];
            end else if (o_outputB) begin
                slaveData <= (slaveIdx[7:4] == 4'h0) ? 16'h0000 : slaveRegs[slaveIdx[7:4]];
            end
            if (o_latchC && o_busValid && (slaveIdx[11:8] != 4'h0)) begin
                slaveRegs[slaveIdx[11:8]] <= o_busData;
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [4:0] expStrobe(input logic [1:0] op, input int cyc);
        logic [4:0] r;
        r = 5'b00000;
        case (op)
            2'b00: case (cyc) 1: r = 5'b10001; 2: r = 5'b01000; 3: r = 5'b00100; default: r = 5'b00000; endcase
            2'b01: case (cyc) 1: r = 5'b10001; 2: r = 5'b00011; default: r = 5'b00000; endcase
            2'b10: case (cyc) 1: r = 5'b10001; 2: r = 5'b01000; 4: r = 5'b00011; default: r = 5'b00000; endcase
            default: r = 5'b00000;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] refGet(input logic [3:0] idx);
        return (idx == 4'h0) ? 16'h0000 : refRegs[idx];
    endfunction

    task automatic runCmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [DW-1:0] data,
                          input int holdCycles, input bit holdValid);
        rsp_t e;
        rsp_t got;
        int expLat;
        int lat;
        int wrCyc;
        logic [4:0] strobes;
        logic [31:0] rnd;
        e.a = 16'h0000; e.b = 16'h0000; e.err = 1'b0; e.dataChk = 1'b1;
        expLat = 1; wrCyc = 0;
        case (op)
            2'b00: begin e.a = refGet(a); e.b = refGet(b); e.err = !busValidEn; expLat = 5; end
            2'b01: begin e.a = data; if (c != 4'h0) refRegs[c] = data; expLat = 3; wrCyc = 2; end
            2'b10: begin e.a = refGet(a); if (c != 4'h0) refRegs[c] = e.a; expLat = 5; wrCyc = 4; end
            default: begin e.err = 1'b1; e.dataChk = 1'b0; expLat = 1; end
        endcase
        expQ.push_back(e);

        @(negedge i_Clk);
        checkValue("cmdReadyIdle", o_cmdReady, 1);
        i_cmdValid = 1'b1; i_cmdOp = op; i_cmdIdxA = a; i_cmdIdxB = b; i_cmdIdxC = c; i_cmdData = data;
        @(posedge i_Clk); #1;
        rnd = $urandom;
        i_cmdValid = 1'b0; i_cmdOp = rnd[1:0]; i_cmdIdxA = rnd[7:4]; i_cmdIdxB = rnd[11:8];
        i_cmdIdxC = rnd[15:12]; i_cmdData = rnd[31:16];

        lat = 0;
        do begin
            @(negedge i_Clk);
            lat++;
            strobes = {o_selectLatch, o_outputA, o_outputB, o_latchC, o_busValid};
            if (!o_rspValid) begin
                checkValue("strobes", {27'd0, strobes}, {27'd0, expStrobe(op, lat)});
                if (lat == 1) checkValue("idxWord", o_busData, {16'h0000, 4'h0, c, b, a});
                if (lat == wrCyc) checkValue("writeData", o_busData, e.a);
            end else begin
                checkValue("rspNoStrobe", {27'd0, strobes}, 32'd0);
            end
        end while (!o_rspValid && lat < 20);
        checkValue("latency", lat, expLat);

        if (holdValid) begin
            i_cmdValid = 1'b1; i_cmdOp = 2'b01; i_cmdIdxC = 4'h7; i_cmdData = 16'h1234;
        end
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge i_Clk);
            checkValue("holdRspValid", o_rspValid, 1);
            checkValue("holdCmdReady", o_cmdReady, 0);
            if (e.dataChk) checkValue("holdRspA", o_rspA, e.a);
            checkValue("holdRspErr", o_rspErr, e.err);
        end
        i_cmdValid = 1'b0;
        i_rspReady = 1'b1;
        if (expQ.size() == 0) begin
            checkValue("sbEmpty", 1, 0);
        end else begin
            got = expQ.pop_front();
            checkValue("rspValid", o_rspValid, 1);
            if (got.dataChk) begin
                checkValue("rspA", o_rspA, got.a);
                checkValue("rspB", o_rspB, got.b);
            end
            checkValue("rspErr", o_rspErr, got.err);
        end
        @(posedge i_Clk); #1;
        i_rspReady = 1'b0;
        @(negedge i_Clk);
        checkValue("postRspValid", o_rspValid, 0);
        checkValue("postCmdReady", o_cmdReady, 1);
    endtask

    initial begin
        logic [31:0] rnd;
        for (int i = 0; i < 16; i++) refRegs[i] = 16'h0000;
        repeat (3) @(negedge i_Clk);
        checkValue("rstCmdReady", o_cmdReady, 1);
        checkValue("rstStrobes", {o_selectLatch, o_outputA, o_outputB, o_latchC, o_busValid}, 0);
        checkValue("rstRspValid", o_rspValid, 0);
        checkValue("rstBusData", o_busData, 0);
        checkValue("rstRspA", o_rspA, 0);
        checkValue("rstRspB", o_rspB, 0);
        checkValue("rstRspErr", o_rspErr, 0);
        slaveClear = 1'b0;
        i_Reset = 1'b0;

        runCmd(2'b01, 4'h0, 4'h0, 4'h3, 16'hBEEF, 0, 1'b0);   // test 1
        runCmd(2'b00, 4'h3, 4'h0, 4'h0, 16'h0000, 0, 1'b0);   // test 2
        runCmd(2'b10, 4'h3, 4'h0, 4'h5, 16'h0000, 0, 1'b0);   // test 3
        runCmd(2'b00, 4'h5, 4'h3, 4'h0, 16'h0000, 0, 1'b0);
        runCmd(2'b00, 4'h5, 4'h3, 4'h0, 16'h0000, 10, 1'b1);  // test 4
        runCmd(2'b00, 4'h7, 4'h5, 4'h0, 16'h0000, 0, 1'b0);   // reg 7 must not hold 0x1234
        runCmd(2'b01, 4'h0, 4'h0, 4'h0, 16'h5555, 0, 1'b0);   // write to index 0 is ignored
        runCmd(2'b00, 4'h0, 4'h3, 4'h0, 16'h0000, 0, 1'b0);

        // test 5: reset during RD_A of a READ
        @(negedge i_Clk);
        i_cmdValid = 1'b1; i_cmdOp = 2'b00; i_cmdIdxA = 4'h3; i_cmdIdxB = 4'h5;
        @(posedge i_Clk); #1;
        i_cmdValid = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        checkValue("t5OutputA", o_outputA, 1);
        i_Reset = 1'b1;
        #1;
        checkValue("t5OutputADrop", o_outputA, 0);
        checkValue("t5NoRsp", o_rspValid, 0);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_Clk);
            checkValue("t5IdleNoRsp", o_rspValid, 0);
        end
        runCmd(2'b01, 4'h0, 4'h0, 4'h3, 16'hBEEF, 0, 1'b0);

        // test 6: illegal op and missing slave valid
        runCmd(2'b11, 4'h1, 4'h2, 4'h3, 16'hAAAA, 0, 1'b0);
        busValidEn = 1'b0;
        runCmd(2'b00, 4'h3, 4'h5, 4'h0, 16'h0000, 0, 1'b0);
        busValidEn = 1'b1;
        runCmd(2'b00, 4'h3, 4'h5, 4'h0, 16'h0000, 0, 1'b0);   // error is not sticky across commands

        for (int n = 0; n < 24; n++) begin
            rnd = $urandom;
            runCmd((rnd[3:0] == 4'hF) ? 2'b11 : ((rnd[5:4] == 2'b11) ? 2'b00 : rnd[5:4]),
                   rnd[11:8], rnd[15:12], rnd[19:16], rnd[31:16], int'(rnd[21:20]), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
